// File: rtl/la_clkgate_pkg.sv
// Shared types and constants for the clock-gate control slice.
package la_clkgate_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_DRAIN = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_t;

    localparam int unsigned WAKECYC_MIN = 1;
    localparam int unsigned WAKECYC_MAX = 15;
    localparam int unsigned WAKECW      = 4;
    localparam int unsigned STATSW      = 32;

endpackage

// File: rtl/la_clkgate_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module la_clkgate_satcnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/la_clkgatectrl.sv
// Enable generator for an OR-style clock gate with 4-phase quiesce handshake.
// Optional gated-cycle statistic: define LA_CLKGATECTRL_STATS_EN.
module la_clkgatectrl
    import la_clkgate_pkg::*;
#(
    parameter              PROP    = "DEFAULT",
    parameter int unsigned IDLECW  = 8,
    parameter int unsigned WAKECYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic              force_on,
    input  logic              wake,
    input  logic [IDLECW-1:0] idle_thresh,
    input  logic              qack,
    output logic              en,
    output logic              qreq,
    output logic              ready,
    output logic [1:0]        state,
    output logic [31:0]       gated_cycles
);

    if ((WAKECYC < WAKECYC_MIN) || (WAKECYC > WAKECYC_MAX)) begin : g_bad_wakecyc
        $error("la_clkgatectrl: WAKECYC out of range 1..15");
    end
    if ($bits(PROP) == 0) begin : g_bad_prop
        $error("la_clkgatectrl: PROP must be non-empty");
    end

    localparam logic [IDLECW-1:0] THRESH_ONE = IDLECW'(1);
    localparam logic [WAKECW-1:0] WAKE_LOAD  = WAKECW'(WAKECYC);

    cg_state_t         state_q;
    cg_state_t         state_n;
    logic              idle;
    logic              idle_hit;
    logic              idle_inc;
    logic              idle_clr;
    logic [IDLECW-1:0] idle_cnt;
    logic [WAKECW-1:0] wake_cnt;
    logic              en_n;
    logic              qreq_n;
    logic              ready_n;

    assign idle     = !busy && !force_on;
    assign idle_hit = (idle_thresh != '0) && idle && (idle_cnt == idle_thresh - THRESH_ONE);
    assign idle_inc = (state_q == CG_RUN) && idle;
    // Holding the count at zero while auto-gating is disabled lets a later
    // non-zero threshold take effect from a clean start.
    assign idle_clr = (state_q != CG_RUN) || !idle || (idle_thresh == '0);

    la_clkgate_satcnt #(.W(IDLECW)) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (idle_clr),
        .inc   (idle_inc),
        .cnt   (idle_cnt)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            CG_RUN:   if (idle_hit) state_n = CG_DRAIN;
            CG_DRAIN: begin
                if (!idle)     state_n = CG_RUN;
                else if (qack) state_n = CG_GATED;
            end
            CG_GATED: if (!idle || wake) state_n = CG_WAKE;
            CG_WAKE:  if ((wake_cnt == '0) && !qack) state_n = CG_RUN;
            default:  state_n = CG_RUN;
        endcase
        // Outputs are decoded from the next state so they leave a flop.
        en_n    = (state_n != CG_GATED);
        qreq_n  = (state_n == CG_DRAIN) || (state_n == CG_GATED);
        ready_n = (state_n == CG_RUN) || (state_n == CG_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CG_RUN;
            en       <= 1'b1;
            qreq     <= 1'b0;
            ready    <= 1'b1;
            wake_cnt <= '0;
        end else begin
            state_q <= state_n;
            en      <= en_n;
            qreq    <= qreq_n;
            ready   <= ready_n;
            if ((state_q != CG_WAKE) && (state_n == CG_WAKE)) begin
                wake_cnt <= WAKE_LOAD;
            end else if (wake_cnt != '0) begin
                wake_cnt <= wake_cnt - WAKECW'(1);
            end
        end
    end

    assign state = state_q;

`ifdef LA_CLKGATECTRL_STATS_EN
    la_clkgate_satcnt #(.W(STATSW)) u_gated_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (state_q == CG_GATED),
        .cnt   (gated_cycles)
    );
`else
    assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_la_clkgatectrl.sv
// Self-checking bench for la_clkgatectrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_la_clkgatectrl;

    localparam int unsigned IDLECW   = 8;
    localparam int unsigned WAKECYC  = 2;
    localparam int          IDLE_MAX = (1 << IDLECW) - 1;
`ifdef LA_CLKGATECTRL_STATS_EN
    localparam int          STATS_ON = 1;
`else
    localparam int          STATS_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              busy;
    logic              force_on;
    logic              wake;
    logic [IDLECW-1:0] idle_thresh;
    logic              qack;
    logic              en;
    logic              qreq;
    logic              ready;
    logic [1:0]        state;
    logic [31:0]       gated_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    la_clkgatectrl #(
        .PROP    ("DEFAULT"),
        .IDLECW  (IDLECW),
        .WAKECYC (WAKECYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .busy         (busy),
        .force_on     (force_on),
        .wake         (wake),
        .idle_thresh  (idle_thresh),
        .qack         (qack),
        .en           (en),
        .qreq         (qreq),
        .ready        (ready),
        .state        (state),
        .gated_cycles (gated_cycles)
    );

    // Island responder: qack echoes qreq after qack_dly cycles, or is forced.
    int         qack_mode = 0;
    int         qack_dly  = 2;
    logic [7:0] qhist     = '0;
    logic       resp_q    = 1'b0;
    always @(posedge clk) begin
        #3;
        qhist  = {qhist[6:0], qreq};
        resp_q = qhist[qack_dly];
    end
    assign qack = (qack_mode == 0) ? resp_q : (qack_mode == 1);

    // Behavioural model: phase plus idle-streak length and wake timestamp.
    localparam int P_RUN = 0, P_DRAIN = 1, P_GATED = 2, P_WAKE = 3;
    int     m_phase      = P_RUN;
    int     m_idle_run   = 0;
    int     m_wake_start = 0;
    int     m_cyc        = 0;
    longint m_gated      = 0;
    bit     m_valid      = 1'b0;
    bit     m_idle;

    always @(posedge clk) begin
        m_cyc++;
        m_idle = !busy && !force_on;
        if (reset) begin
            m_phase    = P_RUN;
            m_idle_run = 0;
            m_gated    = 0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                P_RUN: begin
                    if (!m_idle || idle_thresh == 0) begin
                        m_idle_run = 0;
                    end else if (m_idle_run + 1 == int'(idle_thresh)) begin
                        m_phase    = P_DRAIN;
                        m_idle_run = 0;
                    end else if (m_idle_run < IDLE_MAX) begin
                        m_idle_run++;
                    end
                end
                P_DRAIN: begin
                    if (!m_idle)   m_phase = P_RUN;
                    else if (qack) m_phase = P_GATED;
                end
                P_GATED: begin
                    if (m_gated < 64'hFFFF_FFFF) m_gated++;
                    if (!m_idle || wake) begin
                        m_phase      = P_WAKE;
                        m_wake_start = m_cyc + 1;
                    end
                end
                default: begin
                    if ((m_cyc - m_wake_start >= int'(WAKECYC)) && !qack) m_phase = P_RUN;
                end
            endcase
        end
    end

    logic        exp_en, exp_qreq, exp_ready;
    logic [31:0] exp_gc;
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            exp_en    = (m_phase != P_GATED);
            exp_qreq  = (m_phase == P_DRAIN) || (m_phase == P_GATED);
            exp_ready = (m_phase == P_RUN) || (m_phase == P_DRAIN);
            exp_gc    = (STATS_ON != 0) ? m_gated[31:0] : 32'd0;
            n_tests++;
            if (en !== exp_en || qreq !== exp_qreq || ready !== exp_ready ||
                state !== 2'(m_phase) || gated_cycles !== exp_gc) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got en=%b qreq=%b ready=%b state=%0d gc=%0d expected en=%b qreq=%b ready=%b state=%0d gc=%0d",
                         $time, en, qreq, ready, state, gated_cycles,
                         exp_en, exp_qreq, exp_ready, m_phase, exp_gc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int max, output int n);
        n = 0;
        while (state !== tgt && n < max) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int left;
        reset = 1'b1; busy = 1'b0; force_on = 1'b0; wake = 1'b0; idle_thresh = 4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_en", en, 1);
        check("reset_qreq", qreq, 0);
        check("reset_ready", ready, 1);
        check("reset_state", state, 0);
        check("reset_gc", gated_cycles, 0);

        wait_state(2'd1, 20, n);
        check("drain_after_4_idle", n, 4);
        check("drain_qreq", qreq, 1);
        check("drain_en", en, 1);
        wait_state(2'd2, 20, n);
        check("gated_after_qack", n, 3);
        check("gated_en", en, 0);
        check("gated_ready", ready, 0);

        repeat (36) @(negedge clk);
        @(negedge clk);
        wake = 1'b1;
        qack_dly = 1;
        @(posedge clk);
        #2;
        check("wake_state", state, 3);
        check("wake_en", en, 1);
        check("wake_ready", ready, 0);
        check("gc_after_37", gated_cycles, (STATS_ON != 0) ? 37 : 0);
        @(negedge clk);
        wake = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("ready_after_wake", n, 3);
        check("run_after_wake", state, 0);

        wait_state(2'd1, 20, n);
        check("redrain_after_4_idle", n, 4);
        @(negedge clk);
        busy = 1'b1;
        qack_mode = 1;
        @(posedge clk);
        #2;
        check("abort_state", state, 0);
        check("abort_en", en, 1);
        check("abort_qreq", qreq, 0);
        @(negedge clk);
        busy = 1'b0;
        qack_mode = 0;
        wait_state(2'd1, 20, n);
        check("counter_restart", n, 4);
        wait_state(2'd2, 20, n);
        check("gate_again", state, 2);
        check("gc_hold", gated_cycles, (STATS_ON != 0) ? 37 : 0);

        @(negedge clk);
        idle_thresh = 0;
        wake = 1'b1;
        @(negedge clk);
        wake = 1'b0;
        wait_state(2'd0, 20, n);
        check("thresh0_run", state, 0);
        left = 0;
        repeat (1000) begin
            @(posedge clk);
            #2;
            if (state !== 2'd0) left = 1;
        end
        check("thresh0_stays_run", left, 0);
        @(negedge clk);
        idle_thresh = 1;
        wait_state(2'd1, 4, n);
        check("thresh1_drain", n, 1);

        @(negedge clk);
        busy = 1'b1;
        idle_thresh = 8;
        @(negedge clk);
        busy = 1'b0;
        wait_state(2'd0, 20, n);
        check("midcount_run", state, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        idle_thresh = 3;
        left = 0;
        repeat (20) begin
            @(posedge clk);
            #2;
            if (state !== 2'd0) left = 1;
        end
        check("thresh_lowered_no_gate", left, 0);
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        wait_state(2'd1, 20, n);
        check("thresh_lowered_after_busy", n, 3);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            busy     = ($urandom_range(0, 99) < 25);
            force_on = ($urandom_range(0, 99) < 4);
            wake     = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 39) == 0) idle_thresh = IDLECW'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0) idle_thresh = IDLECW'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) qack_dly = $urandom_range(1, 3);
            if (qack_mode != 0) begin
                if ($urandom_range(0, 7) == 0) qack_mode = 0;
            end else if ($urandom_range(0, 199) == 0) begin
                qack_mode = $urandom_range(1, 2);
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        reset = 1'b0; busy = 1'b0; force_on = 1'b0; wake = 1'b0; qack_mode = 0;
        repeat (5) @(posedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
